// File: rtl/spatial_conv_mac_pipe.sv
// spatial_conv_mac_pipe: pipelined multi-channel KxK convolution MAC with saturated Q-format output
// Build option: define SPATIAL_CONV_RELU_EN to clamp negative results to zero after saturation.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready   beat handshake; window/kernel are packed row-major taps, tap 0 in the LSBs
//   out_valid, out_ready result handshake
//   result               saturated signed result, FRAC_WIDTH fractional bits
//   out_overflow         result was saturated (qualified by out_valid)
//   overflow_sticky      any result saturated since reset
//   chan_idx             channel index of the next beat to be accepted
module spatial_conv_mac_pipe #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int IN_CHANNELS = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] window,
    input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] kernel,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [DATA_WIDTH-1:0]                         result,
    output logic                                          out_overflow,
    output logic                                          overflow_sticky,
    output logic [(IN_CHANNELS > 1 ? $clog2(IN_CHANNELS) : 1)-1:0] chan_idx
);
    localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int ACC_W = PW + $clog2(KK * IN_CHANNELS);
    localparam int CW    = IN_CHANNELS > 1 ? $clog2(IN_CHANNELS) : 1;
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic                    adv, accept;
    logic signed [PW-1:0]    prod [KK];
    logic                    v1, last1, v2, last2, v3;
    logic signed [ACC_W-1:0] tree, sum2, acc, total, shifted;
    logic                    ovf_n;
    logic [DATA_WIDTH-1:0]   sat_n, res_n;

    assign in_ready = !(out_valid && !out_ready);
    assign adv      = in_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        tree = '0;
        for (int i = 0; i < KK; i++) tree = tree + ACC_W'(prod[i]);
    end

    // The wide group total is registered first and clamped a cycle later,
    // keeping the final add and the saturation compare in separate cycles.
    always_comb begin
        shifted = total >>> FRAC_WIDTH;
        ovf_n   = shifted > MAXV || shifted < MINV;
        sat_n   = !ovf_n ? shifted[DATA_WIDTH-1:0]
                : shifted[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`ifdef SPATIAL_CONV_RELU_EN
        res_n   = sat_n[DATA_WIDTH-1] ? '0 : sat_n;
`else
        res_n   = sat_n;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KK; i++) prod[i] <= '0;
            chan_idx        <= '0;
            v1              <= 1'b0;
            last1           <= 1'b0;
            v2              <= 1'b0;
            last2           <= 1'b0;
            sum2            <= '0;
            v3              <= 1'b0;
            acc             <= '0;
            total           <= '0;
            out_valid       <= 1'b0;
            result          <= '0;
            out_overflow    <= 1'b0;
            overflow_sticky <= 1'b0;
        end else if (adv) begin
            v1 <= accept;
            if (accept) begin
                for (int i = 0; i < KK; i++)
                    prod[i] <= $signed(window[i*DATA_WIDTH +: DATA_WIDTH]) * $signed(kernel[i*DATA_WIDTH +: DATA_WIDTH]);
                last1    <= chan_idx == CW'(IN_CHANNELS - 1);
                chan_idx <= chan_idx == CW'(IN_CHANNELS - 1) ? '0 : chan_idx + 1'b1;
            end
            v2    <= v1;
            last2 <= last1;
            sum2  <= tree;
            v3    <= v2 && last2;
            if (v2) begin
                acc <= last2 ? '0 : acc + sum2;
                if (last2) total <= acc + sum2;
            end
            out_valid <= v3;
            if (v3) begin
                result          <= res_n;
                out_overflow    <= ovf_n;
                overflow_sticky <= overflow_sticky | ovf_n;
            end
        end
    end
endmodule
